// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: instruction width, bubble encoding
// and the {pc, instr} record carried through the fetch buffer.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched entries; DEPTH must be a power of
// two so the read/write pointers wrap on their own. Flush beats push and pop.
module fetch_fifo import cpu_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type EntryT = fetch_entry_t,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  EntryT            pushData_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output EntryT            head_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  EntryT            mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign doPush = push_i && !flush_i && ((count_q != FULL_CNT) || pop_i);
  assign doPop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues word requests to imem, buffers in-order
// responses in a prefetch FIFO and presents the head to decode.
module cpu_fetch import cpu_pkg::*; #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rw_stall,
  input  logic               jb_stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
);

  localparam int               CNT_W     = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_CAP = (CNT_W + 1)'(BUF_DEPTH);

  logic [PC_W-1:0]  fetchPc_q, fetchPc_d;
  logic [PC_W-1:0]  ifPc_q, ifPc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

  logic [CNT_W-1:0] fifoCount;
  fetch_entry_t     fifoHead, pushEntry;
  logic [CNT_W:0]   inFlight;
  logic [PC_W-1:0]  rspPc;
  logic             reqValid, reqFire, dropRsp, pushRsp, outValid, popHead;

  // Credit check: never have more words requested or buffered than the FIFO holds.
  assign inFlight = {1'b0, fifoCount} + {1'b0, outstanding_q};
  assign reqValid = rst_n && !br_taken && !jb_stall && (inFlight < DEPTH_CAP);
  assign reqFire  = reqValid && imem_req_ready;

  assign dropRsp = imem_rsp_valid && ((dropCnt_q != '0) || br_taken);
  assign pushRsp = imem_rsp_valid && !dropRsp;

  // The oldest live request sits outstanding words behind the next fetch address.
  assign rspPc           = fetchPc_q - (PC_W'(outstanding_q) << 2);
  assign pushEntry.pc    = ADDR_W'(rspPc);
  assign pushEntry.instr = imem_rsp_data;

  assign outValid = rst_n && (fifoCount != '0) && !jb_stall;
  assign popHead  = outValid && !rw_stall && !br_taken;

  fetch_fifo #(
    .DEPTH  (BUF_DEPTH),
    .EntryT (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pushRsp),
    .pushData_i (pushEntry),
    .pop_i      (popHead),
    .flush_i    (br_taken),
    .count_o    (fifoCount),
    .head_o     (fifoHead)
  );

  // On a redirect every request still in flight belongs to the old path.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);
    dropCnt_d     = dropCnt_q;
    ifPc_d        = outValid ? fifoHead.pc[PC_W-1:0] : ifPc_q;
    if (br_taken) begin
      fetchPc_d = br_target;
      dropCnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + PC_W'(4);
      if (imem_rsp_valid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc_q     <= RESET_PC;
      ifPc_q        <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      ifPc_q        <= ifPc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
    end
  end

  assign imem_req_valid = reqValid;
  assign imem_req_addr  = fetchPc_q;
  assign if_valid       = outValid;
  assign if_instr       = outValid ? fifoHead.instr : NOP_INSTR;
  assign if_pc          = outValid ? fifoHead.pc[PC_W-1:0] : ifPc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: memory model returning word = address, an in-order
// instruction scoreboard, a stall vector table and hand-written corner cases.
module tb_cpu_fetch;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rw_stall = 1'b0;
  logic        jb_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  cpu_fetch #(
    .PC_W      (32),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rw_stall       (rw_stall),
    .jb_stall       (jb_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid)
  );

  initial forever #5 clk = ~clk;

  int nChecks = 0;
  int nFail = 0;
  int consumed = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Memory: accepts are sampled late in the cycle, answered memLat cycles later, in order.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  int          cycleCnt = 0;
  int          memLat = 1;
  bit          rstS = 1'b0;
  bit          acceptS = 1'b0;
  bit          rspTakenS = 1'b0;
  logic [31:0] addrS = 32'h0;

  initial forever begin
    @(posedge clk);
    cycleCnt++;
    if (!rstS) begin
      memQ.delete();
    end else begin
      if (rspTakenS && memQ.size() > 0) void'(memQ.pop_front());
      if (acceptS) memQ.push_back('{addrS, cycleCnt + memLat - 1});
    end
    #1;
    if (memQ.size() > 0 && memQ[0].due <= cycleCnt) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memQ[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #8;
    rstS      = rst_n;
    acceptS   = imem_req_valid && imem_req_ready;
    rspTakenS = imem_rsp_valid;
    addrS     = imem_req_addr;
  end

  // Scoreboard of the expected program-order stream; restarts on redirect or reset.
  logic [31:0] expQ[$];

  task automatic refill(input logic [31:0] base);
    expQ.delete();
    for (int i = 0; i < 256; i++) expQ.push_back(base + 32'(4 * i));
  endtask

  initial forever begin
    logic [31:0] expWord;
    @(posedge clk);
    #6;
    if (!rst_n) begin
      refill(RESET_PC);
    end else if (br_taken) begin
      refill(br_target);
    end else begin
      if (if_valid && !rw_stall) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL scoreboard empty: actual 0x%08h required none", if_instr);
        end else begin
          expWord = expQ.pop_front();
          checkEq("stream instr", if_instr, expWord);
          checkEq("stream pc", if_pc, expWord);
          consumed++;
        end
      end
      if (!if_valid) checkEq("bubble instr", if_instr, 32'h0);
    end
    checkEq("occupancy bound", 32'(memQ.size() <= BUF_DEPTH), 32'd1);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic rw;
    logic jb;
    logic chkV;
    logic expV;
    logic expReq;
    logic hold;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] heldInstr = 32'h0;
  logic [31:0] heldPc = 32'h0;
  bit          heldSet = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input vec_t v);
    if (v.chkV) begin
      checkEq("table if_valid", 32'(if_valid), 32'(v.expV));
      checkEq("table req_valid", 32'(imem_req_valid), 32'(v.expReq));
      if (!v.expV) checkEq("table bubble", if_instr, 32'h0);
    end
    if (v.hold) begin
      if (!heldSet) begin
        heldInstr = if_instr;
        heldPc    = if_pc;
        heldSet   = 1'b1;
      end else begin
        checkEq("table held instr", if_instr, heldInstr);
        checkEq("table held pc", if_pc, heldPc);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    step();
    rw_stall = v.rw;
    jb_stall = v.jb;
    #5;
    checkOutput(v);
  endtask

  initial begin
    bit found;

    //          rw    jb    chkV  expV  expReq hold
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) step();
    #5;
    checkEq("reset if_valid", 32'(if_valid), 32'd0);
    checkEq("reset if_instr", if_instr, 32'h0);
    checkEq("reset if_pc", if_pc, RESET_PC);
    checkEq("reset req_valid", 32'(imem_req_valid), 32'd0);
    checkEq("reset req_addr", imem_req_addr, RESET_PC);

    step();
    rst_n = 1'b1;
    #5;
    checkEq("first req_valid", 32'(imem_req_valid), 32'd1);
    checkEq("first req_addr", imem_req_addr, RESET_PC);
    step();
    #5;
    checkEq("latency bubble", 32'(if_valid), 32'd0);
    step();
    #5;
    checkEq("latency valid", 32'(if_valid), 32'd1);
    checkEq("latency instr", if_instr, RESET_PC);

    // Catch 0x10 at the head and hold it with rw_stall for five cycles.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #2;
      if (if_valid && if_instr == 32'h10) begin
        rw_stall = 1'b1;
        found = 1'b1;
      end
    end
    checkEq("found 0x10", 32'(found), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      #(k > 1 ? 5 : 3);
      checkEq("rw hold valid", 32'(if_valid), 32'd1);
      checkEq("rw hold instr", if_instr, 32'h10);
      checkEq("rw hold pc", if_pc, 32'h10);
      if (k >= 3) checkEq("rw full no req", 32'(imem_req_valid), 32'd0);
    end
    step();
    rw_stall = 1'b0;
    repeat (6) step();

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
    repeat (4) step();

    // Zero-wait redirect: request at T+1, target valid at T+3.
    step();
    br_taken  = 1'b1;
    br_target = 32'h40;
    #5;
    checkEq("redirect no req", 32'(imem_req_valid), 32'd0);
    step();
    br_taken = 1'b0;
    #5;
    checkEq("redirect req_valid", 32'(imem_req_valid), 32'd1);
    checkEq("redirect req_addr", imem_req_addr, 32'h40);
    step();
    #5;
    checkEq("redirect T+2 bubble", 32'(if_valid), 32'd0);
    step();
    #5;
    checkEq("redirect T+3 valid", 32'(if_valid), 32'd1);
    checkEq("redirect T+3 instr", if_instr, 32'h40);
    checkEq("redirect T+3 pc", if_pc, 32'h40);
    repeat (4) step();

    // Memory not ready: address must hold; a redirect replaces it next cycle.
    step();
    imem_req_ready = 1'b0;
    repeat (4) step();
    #5;
    heldPc = imem_req_addr;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step();
        #5;
      end
      checkEq("wait req_valid", 32'(imem_req_valid), 32'd1);
      checkEq("wait addr stable", imem_req_addr, heldPc);
    end
    step();
    br_taken  = 1'b1;
    br_target = 32'h200;
    step();
    br_taken = 1'b0;
    #5;
    checkEq("wait redirect valid", 32'(imem_req_valid), 32'd1);
    checkEq("wait redirect addr", imem_req_addr, 32'h200);
    step();
    imem_req_ready = 1'b1;
    repeat (6) step();

    // Slow memory: redirect while two requests are in flight.
    memLat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      #2;
      if (memQ.size() == 2 && !imem_rsp_valid) begin
        br_taken  = 1'b1;
        br_target = 32'h100;
        found = 1'b1;
      end
    end
    checkEq("found two outstanding", 32'(found), 32'd1);
    step();
    br_taken = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #5;
      if (if_valid) begin
        found = 1'b1;
        checkEq("drop next instr", if_instr, 32'h100);
        checkEq("drop next pc", if_pc, 32'h100);
      end
    end
    checkEq("target arrived", 32'(found), 32'd1);
    repeat (8) step();

    // Reset for one cycle with responses in flight.
    memLat = 2;
    repeat (8) step();
    step();
    rst_n = 1'b0;
    #5;
    checkEq("mid reset req_valid", 32'(imem_req_valid), 32'd0);
    checkEq("mid reset if_valid", 32'(if_valid), 32'd0);
    step();
    rst_n = 1'b1;
    #5;
    checkEq("post reset if_valid", 32'(if_valid), 32'd0);
    checkEq("post reset if_instr", if_instr, 32'h0);
    checkEq("post reset if_pc", if_pc, RESET_PC);
    checkEq("post reset req_addr", imem_req_addr, RESET_PC);
    checkEq("post reset req_valid", 32'(imem_req_valid), 32'd1);
    repeat (15) step();

    checkEq("stream progress", 32'(consumed > 30), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch stage of the pipelined CPU. Issues word fetches to instruction memory through a valid/ready request port and buffers returned words in a small prefetch FIFO. Presents the head word to decode and to `cpu_stall` as `if_instr`. Consumes `rw_stall` and `jb_stall` from `cpu_stall`, and redirects the PC on a taken branch or jump resolved in execute.

## Interface
- `PC_W`, 32: program counter width (byte address).
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `BUF_DEPTH`, 2: prefetch FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rw_stall` in 1: data hazard on `if_instr`; hold the current instruction.
- `jb_stall` in 1: branch/jump unresolved downstream; emit bubbles and stop fetching.
- `br_taken` in 1: redirect request from execute, one-cycle pulse.
- `br_target` in `PC_W`: redirect address; must be word aligned.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out `PC_W`: fetch address.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: read data valid; responses return in order.
- `imem_rsp_data` in 32: instruction word.
- `if_instr` out 32: instruction presented to decode and `cpu_stall`.
- `if_pc` out `PC_W`: address of `if_instr`.
- `if_valid` out 1: `if_instr` is a real instruction, not a bubble.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - FIFO of {pc, instr} pairs.
  - `outstanding`: accepted requests not yet answered; width clog2(BUF_DEPTH)+1.
  - `drop_cnt`: responses still to be discarded after a redirect.
- Request issue: `imem_req_valid = !br_taken && !jb_stall && (fifo_count + outstanding < BUF_DEPTH)`.
  - When valid && ready: `fetch_pc += 4`, `outstanding++`.
  - Address and valid are held while ready is low, unless a redirect occurs.
- Response handling, when `imem_rsp_valid` is high:
  - Always `outstanding--`.
  - If `drop_cnt != 0` or `br_taken` is high: discard the response and decrement `drop_cnt` if it is nonzero.
  - Otherwise push {pc of that request, data} into the FIFO. The pc comes from a parallel in-order pc queue, or equivalently from `fetch_pc - 4*outstanding`.
- Output path:
  - FIFO non-empty and `!jb_stall`: `if_valid=1`, `if_instr`/`if_pc` = FIFO head.
  - Otherwise `if_valid=0`, `if_instr=NOP_INSTR` (32'h0, matches neither the L nor the R class), `if_pc` holds its last value.
- Pop: on `if_valid && !rw_stall`, the head is consumed at the clock edge.
- Priority: `br_taken` > `jb_stall` > `rw_stall`.
- On `br_taken`, at the clock edge:
  - FIFO is flushed.
  - `fetch_pc = br_target`.
  - `drop_cnt = outstanding` minus any response arriving in the same cycle (that response is discarded directly).
  - No request is issued and no pop occurs in the redirect cycle.
- Counter arithmetic: `outstanding` and `drop_cnt` never exceed BUF_DEPTH; `fetch_pc` wraps modulo 2^PC_W.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `if_valid=0`, `if_instr=32'h0`, `if_pc=RESET_PC`; FIFO empty, counters 0.
- Reset mid-operation discards everything, including in-flight responses. The memory is reset together with this block.
- First request is issued in the first cycle with `rst_n=1`.
- With a zero-wait memory (ready=1, rsp one cycle after accept), the first instruction reaches `if_valid` 2 cycles after request acceptance.
- Sustained throughput is 1 instruction per cycle.
- FIFO data are registered: `if_instr` never depends combinationally on `imem_rsp_data`.
- `if_instr` may depend combinationally on `jb_stall` and FIFO state only, not on `rw_stall`. This keeps the `rw_stall` path free of loops.
- Redirect: `br_taken` in cycle T → request to `br_target` in T+1 → target instruction valid at T+3 with a zero-wait memory.
- Full FIFO with `rw_stall` held: no requests issue and `if_instr` is held indefinitely.
- Empty FIFO: bubble output, with `if_valid=0` and `if_instr=0`.
- Push and pop in the same cycle: occupancy unchanged.

## Structure
- `cpu_pkg` holds `INSTR_W=32`, `NOP_INSTR=32'h0`, and the `fetch_entry_t` struct {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO parameterized by depth and entry type.
  - Provides push, pop, flush, count, and head.
  - Flush has priority over push and pop.
- Everything else (PC, counters, issue logic) lives in `cpu_fetch`.

## Test plan
- Reset release, zero-wait memory returning word = address:
  - Requests go to 0x0, 0x4, 0x8, …
  - `if_instr` shows 0x0, 0x4, … one per cycle, starting 2 cycles after the first accept.
- `rw_stall` high for 5 cycles while `if_instr=0x10`:
  - `if_instr`/`if_pc` held at 0x10.
  - At most BUF_DEPTH requests outstanding or buffered.
  - Resume yields 0x14 with no word lost or duplicated.
- `jb_stall` high for 3 cycles:
  - `if_valid=0`, `if_instr=0`, `imem_req_valid=0`.
  - On release, the buffered head reappears unchanged.
- `br_taken` with `br_target=0x100` while 2 requests are outstanding:
  - Both old responses are dropped.
  - Next `if_instr` is 0x100, and `if_pc` is 0x100.
- `imem_req_ready` low for 4 cycles:
  - `imem_req_addr` is stable throughout.
  - A `br_taken` during the wait changes the address to the target on the next cycle.
- `rst_n` low for one cycle mid-stream with responses in flight:
  - All outputs return to their reset values.
  - Fetch restarts at `RESET_PC`.
